// File: rtl/rx_ts_os_detector.sv
// Receive-side TS1/TS2 ordered-set parser for one 8b/10b lane.
// Frames 16-symbol sets, reports their fields and counts consecutive identical sets.
module rx_ts_os_detector #(
  parameter int CONSEC_THRESH = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             sym_valid_i,
  input  logic [7:0]       sym_data_i,
  input  logic             sym_k_i,
  output logic             ts_valid_o,
  output logic             ts_type_o,
  output logic [7:0]       link_num_o,
  output logic             link_pad_o,
  output logic [4:0]       lane_num_o,
  output logic             lane_pad_o,
  output logic [7:0]       n_fts_o,
  output logic [7:0]       rate_id_o,
  output logic [7:0]       train_ctl_o,
  output logic [CNT_W-1:0] consec_cnt_o,
  output logic             ts1_consec_o,
  output logic             ts2_consec_o,
  output logic             polarity_inv_o,
  output logic             frame_err_o
);

  localparam logic [7:0] COM_C     = 8'hBC;
  localparam logic [7:0] PAD_C     = 8'hF7;
  localparam logic [7:0] TS1_ID_C  = 8'h4A;
  localparam logic [7:0] TS2_ID_C  = 8'h45;
  localparam logic [7:0] TS1_INV_C = 8'hB5;
  localparam logic [7:0] TS2_INV_C = 8'hBA;

  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(CONSEC_THRESH);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_FIELDS = 2'd1,
    ST_IDENT  = 2'd2
  } state_e;

  state_e           state_q;
  logic [3:0]       idx_q;
  logic [7:0]       sh_link_q, sh_lane_q, sh_nfts_q, sh_rate_q, sh_train_q, cand_id_q;
  logic             sh_link_pad_q, sh_lane_pad_q;
  logic             ts_valid_q, ts_type_q, link_pad_q, lane_pad_q, pol_q, ferr_q, prev_vld_q;
  logic [7:0]       link_num_q, lane_full_q, n_fts_q, rate_q, train_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic is_com_s, is_pad_s, is_norm_id_s, is_inv_id_s, id_match_s, sym_ok_s;
  logic type_new_s, cand_inv_s, same_s;

  assign is_com_s     = sym_k_i && (sym_data_i == COM_C);
  assign is_pad_s     = sym_k_i && (sym_data_i == PAD_C);
  assign is_norm_id_s = !sym_k_i && ((sym_data_i == TS1_ID_C) || (sym_data_i == TS2_ID_C));
  assign is_inv_id_s  = !sym_k_i && ((sym_data_i == TS1_INV_C) || (sym_data_i == TS2_INV_C));
  assign id_match_s   = !sym_k_i && (sym_data_i == cand_id_q);
  assign type_new_s   = (cand_id_q == TS2_ID_C);
  assign cand_inv_s   = (cand_id_q == TS1_INV_C) || (cand_id_q == TS2_INV_C);

  // The previous-set reference is simply the held output fields, qualified by prev_vld_q.
  assign same_s = prev_vld_q && (ts_type_q == type_new_s) &&
                  (link_num_q == sh_link_q) && (link_pad_q == sh_link_pad_q) &&
                  (lane_full_q == sh_lane_q) && (lane_pad_q == sh_lane_pad_q) &&
                  (n_fts_q == sh_nfts_q) && (rate_q == sh_rate_q) && (train_q == sh_train_q);

  // Legality of the presented symbol at the current set position.
  always_comb begin
    sym_ok_s = 1'b0;
    case (state_q)
      ST_FIELDS: begin
        if (idx_q <= 4'd2) sym_ok_s = is_pad_s || !sym_k_i;
        else               sym_ok_s = !sym_k_i;
      end
      ST_IDENT: begin
        if (idx_q == 4'd6) sym_ok_s = is_norm_id_s || is_inv_id_s;
        else               sym_ok_s = id_match_s;
      end
      default: sym_ok_s = 1'b0;
    endcase
  end

  // Next consecutive count for a completing normal set.
  always_comb begin
    cnt_d = CNT_ONE_C;
    if (same_s) begin
      if (cnt_q == CNT_MAX_C) cnt_d = cnt_q;
      else                    cnt_d = cnt_q + CNT_ONE_C;
    end else begin
      cnt_d = CNT_ONE_C;
    end
  end

  // Framing FSM, shadow capture, completion and counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_HUNT;
      idx_q         <= 4'd0;
      sh_link_q     <= 8'd0;
      sh_link_pad_q <= 1'b0;
      sh_lane_q     <= 8'd0;
      sh_lane_pad_q <= 1'b0;
      sh_nfts_q     <= 8'd0;
      sh_rate_q     <= 8'd0;
      sh_train_q    <= 8'd0;
      cand_id_q     <= 8'd0;
      ts_valid_q    <= 1'b0;
      ts_type_q     <= 1'b0;
      link_num_q    <= 8'd0;
      link_pad_q    <= 1'b0;
      lane_full_q   <= 8'd0;
      lane_pad_q    <= 1'b0;
      n_fts_q       <= 8'd0;
      rate_q        <= 8'd0;
      train_q       <= 8'd0;
      cnt_q         <= {CNT_W{1'b0}};
      pol_q         <= 1'b0;
      ferr_q        <= 1'b0;
      prev_vld_q    <= 1'b0;
    end else begin
      ts_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      if (clear_i) begin
        state_q    <= ST_HUNT;
        idx_q      <= 4'd0;
        cnt_q      <= {CNT_W{1'b0}};
        pol_q      <= 1'b0;
        prev_vld_q <= 1'b0;
      end else if (sym_valid_i) begin
        case (state_q)
          ST_HUNT: begin
            if (is_com_s) begin
              state_q <= ST_FIELDS;
              idx_q   <= 4'd1;
            end
          end
          ST_FIELDS, ST_IDENT: begin
            if (is_com_s) begin
              // Resync: the new COM starts a fresh set.
              ferr_q  <= 1'b1;
              cnt_q   <= {CNT_W{1'b0}};
              state_q <= ST_FIELDS;
              idx_q   <= 4'd1;
            end else if (!sym_ok_s) begin
              ferr_q  <= 1'b1;
              cnt_q   <= {CNT_W{1'b0}};
              state_q <= ST_HUNT;
            end else begin
              case (idx_q)
                4'd1:    begin sh_link_q <= sym_data_i; sh_link_pad_q <= sym_k_i; end
                4'd2:    begin sh_lane_q <= sym_data_i; sh_lane_pad_q <= sym_k_i; end
                4'd3:    sh_nfts_q  <= sym_data_i;
                4'd4:    sh_rate_q  <= sym_data_i;
                4'd5:    sh_train_q <= sym_data_i;
                4'd6:    cand_id_q  <= sym_data_i;
                default: ;
              endcase
              if (idx_q == 4'd15) begin
                state_q <= ST_HUNT;
                if (cand_inv_s) begin
                  pol_q <= 1'b1;
                end else begin
                  ts_valid_q  <= 1'b1;
                  ts_type_q   <= type_new_s;
                  link_num_q  <= sh_link_q;
                  link_pad_q  <= sh_link_pad_q;
                  lane_full_q <= sh_lane_q;
                  lane_pad_q  <= sh_lane_pad_q;
                  n_fts_q     <= sh_nfts_q;
                  rate_q      <= sh_rate_q;
                  train_q     <= sh_train_q;
                  cnt_q       <= cnt_d;
                  prev_vld_q  <= 1'b1;
                end
              end else begin
                idx_q <= idx_q + 4'd1;
                if (idx_q == 4'd5) state_q <= ST_IDENT;
              end
            end
          end
          default: state_q <= ST_HUNT;
        endcase
      end
    end
  end

  assign ts_valid_o     = ts_valid_q;
  assign ts_type_o      = ts_type_q;
  assign link_num_o     = link_num_q;
  assign link_pad_o     = link_pad_q;
  assign lane_num_o     = lane_full_q[4:0];
  assign lane_pad_o     = lane_pad_q;
  assign n_fts_o        = n_fts_q;
  assign rate_id_o      = rate_q;
  assign train_ctl_o    = train_q;
  assign consec_cnt_o   = cnt_q;
  assign ts1_consec_o   = (cnt_q >= THRESH_C) && !ts_type_q;
  assign ts2_consec_o   = (cnt_q >= THRESH_C) && ts_type_q;
  assign polarity_inv_o = pol_q;
  assign frame_err_o    = ferr_q;

endmodule

// File: tb/tb_rx_ts_os_detector.sv
// Bench for rx_ts_os_detector: set-level reference model checked every cycle,
// plus literal expectations at key points of the directed stimulus.
module tb_rx_ts_os_detector;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] T1  = 8'h4A;
  localparam logic [7:0] T2  = 8'h45;
  localparam logic [7:0] I1  = 8'hB5;
  localparam logic [7:0] I2  = 8'hBA;

  logic clk_i = 1'b0, rst_i, clear_i, sym_valid_i, sym_k_i;
  logic [7:0] sym_data_i;
  logic ts_valid_o, ts_type_o, link_pad_o, lane_pad_o, ts1_consec_o, ts2_consec_o;
  logic polarity_inv_o, frame_err_o;
  logic [7:0] link_num_o, n_fts_o, rate_id_o, train_ctl_o;
  logic [4:0] lane_num_o;
  logic [3:0] consec_cnt_o;

  rx_ts_os_detector #(.CONSEC_THRESH(8), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .sym_valid_i(sym_valid_i),
    .sym_data_i(sym_data_i), .sym_k_i(sym_k_i), .ts_valid_o(ts_valid_o),
    .ts_type_o(ts_type_o), .link_num_o(link_num_o), .link_pad_o(link_pad_o),
    .lane_num_o(lane_num_o), .lane_pad_o(lane_pad_o), .n_fts_o(n_fts_o),
    .rate_id_o(rate_id_o), .train_ctl_o(train_ctl_o), .consec_cnt_o(consec_cnt_o),
    .ts1_consec_o(ts1_consec_o), .ts2_consec_o(ts2_consec_o),
    .polarity_inv_o(polarity_inv_o), .frame_err_o(frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  bit run_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a set is collected in a queue after COM and judged as a whole.
  bit m_in_set, m_prev_vld;
  logic [8:0] set_q[$];
  bit e_valid, e_ferr, e_type, e_lpad, e_npad, e_pol;
  logic [7:0] e_link, e_lane, e_nfts, e_rate, e_train;
  int e_cnt;

  function automatic void model_reset();
    m_in_set = 0; m_prev_vld = 0; set_q.delete();
    e_valid = 0; e_ferr = 0; e_type = 0; e_lpad = 0; e_npad = 0; e_pol = 0;
    e_link = 8'h00; e_lane = 8'h00; e_nfts = 8'h00; e_rate = 8'h00; e_train = 8'h00;
    e_cnt = 0;
  endfunction

  function automatic void model_finish();
    logic [7:0] id;
    bit typ, same;
    id = set_q[5][7:0];
    if (id == I1 || id == I2) begin
      e_pol = 1;
    end else begin
      typ = (id == T2);
      same = m_prev_vld && (typ == e_type) && (set_q[0] == {e_lpad, e_link}) &&
             (set_q[1] == {e_npad, e_lane}) && (set_q[2][7:0] == e_nfts) &&
             (set_q[3][7:0] == e_rate) && (set_q[4][7:0] == e_train);
      e_cnt = same ? ((e_cnt < 15) ? e_cnt + 1 : 15) : 1;
      e_valid = 1; e_type = typ; m_prev_vld = 1;
      {e_lpad, e_link} = set_q[0];
      {e_npad, e_lane} = set_q[1];
      e_nfts = set_q[2][7:0]; e_rate = set_q[3][7:0]; e_train = set_q[4][7:0];
    end
  endfunction

  function automatic void model_step(input bit v, input bit k, input logic [7:0] d, input bit clr);
    int pos;
    bit ok;
    e_valid = 0; e_ferr = 0;
    if (clr) begin
      m_in_set = 0; e_cnt = 0; e_pol = 0; m_prev_vld = 0;
    end else if (v) begin
      if (!m_in_set) begin
        if (k && d == COM) begin m_in_set = 1; set_q.delete(); end
      end else if (k && d == COM) begin
        e_ferr = 1; e_cnt = 0; set_q.delete();
      end else begin
        pos = set_q.size() + 1;
        if (pos <= 2)      ok = !k || d == PAD;
        else if (pos <= 5) ok = !k;
        else if (pos == 6) ok = !k && (d == T1 || d == T2 || d == I1 || d == I2);
        else               ok = !k && d == set_q[5][7:0];
        if (!ok) begin
          e_ferr = 1; e_cnt = 0; m_in_set = 0;
        end else begin
          set_q.push_back({k, d});
          if (pos == 15) begin m_in_set = 0; model_finish(); end
        end
      end
    end
  endfunction

  // Every-cycle comparison against the model.
  always @(negedge clk_i) begin
    if (run_chk) begin
      chk("ts_valid", ts_valid_o, e_valid);
      chk("frame_err", frame_err_o, e_ferr);
      chk("ts_type", ts_type_o, e_type);
      chk("link_num", link_num_o, e_link);
      chk("link_pad", link_pad_o, e_lpad);
      chk("lane_num", lane_num_o, e_lane[4:0]);
      chk("lane_pad", lane_pad_o, e_npad);
      chk("n_fts", n_fts_o, e_nfts);
      chk("rate_id", rate_id_o, e_rate);
      chk("train_ctl", train_ctl_o, e_train);
      chk("consec_cnt", consec_cnt_o, e_cnt);
      chk("ts1_consec", ts1_consec_o, (e_cnt >= 8) && !e_type);
      chk("ts2_consec", ts2_consec_o, (e_cnt >= 8) && e_type);
      chk("polarity_inv", polarity_inv_o, e_pol);
    end
  end

  logic       ts_k[16];
  logic [7:0] ts_d[16];

  task automatic make_ts(input logic [7:0] id, input logic lk, input logic [7:0] ld,
                         input logic nk, input logic [7:0] nd, input logic [7:0] rate);
    ts_k[0] = 1'b1; ts_d[0] = COM;
    ts_k[1] = lk;   ts_d[1] = ld;
    ts_k[2] = nk;   ts_d[2] = nd;
    ts_k[3] = 1'b0; ts_d[3] = 8'h1F;
    ts_k[4] = 1'b0; ts_d[4] = rate;
    ts_k[5] = 1'b0; ts_d[5] = 8'h00;
    for (int i = 6; i < 16; i++) begin ts_k[i] = 1'b0; ts_d[i] = id; end
  endtask

  task automatic cyc(input bit v, input bit k, input logic [7:0] d, input bit clr);
    sym_valid_i = v; sym_k_i = k; sym_data_i = d; clear_i = clr;
    @(posedge clk_i);
    if (rst_i) model_reset();
    else       model_step(v, k, d, clr);
    @(negedge clk_i);
    #1;
  endtask

  task automatic send(input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      if (gaps && $urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) cyc(1'b0, 1'b1, COM, 1'b0);
      cyc(1'b1, ts_k[i], ts_d[i], 1'b0);
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; sym_valid_i = 1'b0; sym_k_i = 1'b0; sym_data_i = 8'h00;
    model_reset();
    run_chk = 1'b1;
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    chk("lit_reset_cnt", consec_cnt_o, 0);
    chk("lit_reset_valid", ts_valid_o, 0);
    rst_i = 1'b0;

    // Eight identical TS1, link/lane PAD, rate 0x02.
    make_ts(T1, 1'b1, PAD, 1'b1, PAD, 8'h02);
    for (int n = 0; n < 8; n++) begin
      send(0, 15, 1'b0);
      chk("lit_b2b_valid", ts_valid_o, 1);
      chk("lit_b2b_cnt", consec_cnt_o, n + 1);
    end
    chk("lit_b2b_ts1c", ts1_consec_o, 1);
    chk("lit_b2b_linkpad", link_pad_o, 1);
    chk("lit_b2b_rate", rate_id_o, 8'h02);

    // Same stream with gaps after a clear.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int n = 0; n < 8; n++) send(0, 15, 1'b1);
    chk("lit_gap_cnt", consec_cnt_o, 8);
    chk("lit_gap_ts1c", ts1_consec_o, 1);

    // 5 TS1, 1 TS1 with link 0x03, then 8 TS2.
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    for (int n = 0; n < 5; n++) send(0, 15, 1'b0);
    chk("lit_mix_cnt5", consec_cnt_o, 5);
    make_ts(T1, 1'b0, 8'h03, 1'b1, PAD, 8'h02);
    send(0, 15, 1'b0);
    chk("lit_mix_cnt1", consec_cnt_o, 1);
    chk("lit_mix_link", link_num_o, 8'h03);
    make_ts(T2, 1'b0, 8'h03, 1'b0, 8'h04, 8'h02);
    for (int n = 0; n < 8; n++) begin
      send(0, 15, 1'b0);
      chk("lit_ts2_cnt", consec_cnt_o, n + 1);
      chk("lit_ts2_ts1c", ts1_consec_o, 0);
    end
    chk("lit_ts2_ts2c", ts2_consec_o, 1);
    chk("lit_ts2_type", ts_type_o, 1);
    chk("lit_ts2_lane", lane_num_o, 5'd4);

    // ID mismatch at symbol 9.
    make_ts(T1, 1'b1, PAD, 1'b1, PAD, 8'h02);
    ts_d[9] = T2;
    send(0, 9, 1'b0);
    chk("lit_mism_ferr", frame_err_o, 1);
    chk("lit_mism_cnt", consec_cnt_o, 0);
    send(10, 15, 1'b0);
    chk("lit_mism_novalid", ts_valid_o, 0);

    // COM at symbol 10, then a complete resynced TS1.
    make_ts(T1, 1'b1, PAD, 1'b1, PAD, 8'h02);
    ts_k[10] = 1'b1; ts_d[10] = COM;
    send(0, 10, 1'b0);
    chk("lit_resync_ferr", frame_err_o, 1);
    make_ts(T1, 1'b1, PAD, 1'b1, PAD, 8'h02);
    send(1, 15, 1'b0);
    chk("lit_resync_valid", ts_valid_o, 1);
    chk("lit_resync_cnt", consec_cnt_o, 1);

    // Inverted TS1 identifier, then clear.
    make_ts(I1, 1'b1, PAD, 1'b1, PAD, 8'h02);
    send(0, 15, 1'b0);
    chk("lit_inv_pol", polarity_inv_o, 1);
    chk("lit_inv_novalid", ts_valid_o, 0);
    chk("lit_inv_cnt", consec_cnt_o, 1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("lit_clr_pol", polarity_inv_o, 0);
    chk("lit_clr_cnt", consec_cnt_o, 0);
    chk("lit_clr_rate_held", rate_id_o, 8'h02);

    // Sixteen TS1: saturation.
    make_ts(T1, 1'b1, PAD, 1'b1, PAD, 8'h02);
    for (int n = 0; n < 16; n++) send(0, 15, 1'b0);
    chk("lit_sat_cnt", consec_cnt_o, 15);

    // Asynchronous reset in the middle of a set.
    send(0, 6, 1'b0);
    rst_i = 1'b1;
    model_reset();
    #1;
    chk("lit_arst_cnt", consec_cnt_o, 0);
    chk("lit_arst_rate", rate_id_o, 0);
    chk("lit_arst_linkpad", link_pad_o, 0);
    chk("lit_arst_ts1c", ts1_consec_o, 0);
    cyc(1'b1, ts_k[7], ts_d[7], 1'b0);
    cyc(1'b1, ts_k[8], ts_d[8], 1'b0);
    rst_i = 1'b0;
    send(0, 15, 1'b0);
    chk("lit_post_rst_valid", ts_valid_o, 1);
    chk("lit_post_rst_cnt", consec_cnt_o, 1);

    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
